seq_barrel_shifter: RTL

- Parametrised, multi-mode, iterative shifter for the ALU datapath. It generalises the fixed 32-bit arithmetic right shift to any power-of-two width.
- Supports four modes: SLL, SRL, SRA and ROR.
- Resolves one shift-amount bit per clock, using one log-stage per cycle instead of a full 32-input mux per bit.
- Uses valid/ready handshakes on both sides so it can sit between the operand register stage and the ALU result mux.

---
 rtl/seq_barrel_shifter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_barrel_shifter.sv
// seq_barrel_shifter: iterative multi-mode shifter (SLL, SRL, SRA, ROR).
// Resolves one shift-amount bit per clock with valid/ready on both sides.
// Optional macro SEQ_BARREL_SHIFTER_FAST_PATH_EN: commands whose effective
// amount is zero skip the SHIFT phase and complete one edge after accept.
module seq_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SLL, SRL, SRA, ROR} mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   amt_q, amt_d;
  // One-hot stage marker: bit k set while stage k is pending, so its value
  // is also the shift distance 2^k for that stage.
  logic [SHW-1:0]   stage_q, stage_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             ozero_q, ozero_d;

  logic             oor;
  logic [WIDTH-1:0] ld_data;
  logic [SHW-1:0]   ld_amt;
  logic [SHW-1:0]   step;
  logic [SHW:0]     rot_back;
  logic [WIDTH-1:0] shifted;

  // Any amount bit at or above SHW means the amount is at least WIDTH.
  generate
    if (AMT_W > SHW) begin : g_oor
      assign oor = |in_amt[AMT_W-1:SHW];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  // Operand/amount to latch at accept, with out-of-range overrides.
  always_comb begin
    ld_data = in_data;
    ld_amt  = in_amt[SHW-1:0];
    if (oor) begin
      case (mode_t'(in_mode))
        SLL, SRL: begin
          ld_data = '0;
          ld_amt  = '0;
        end
        SRA: begin
          ld_data = {WIDTH{in_data[WIDTH-1]}};
          ld_amt  = '0;
        end
        default: ;
      endcase
    end
  end

  // One log-stage of the shifter: shift by 2^stage if that amount bit is set.
  always_comb begin
    step     = (|(amt_q & stage_q)) ? stage_q : '0;
    rot_back = (SHW+1)'(WIDTH) - (SHW+1)'(step);
    case (mode_q)
      SLL:     shifted = data_q << step;
      SRL:     shifted = data_q >> step;
      SRA:     shifted = $signed(data_q) >>> step;
      default: shifted = (data_q >> step) | (data_q << rot_back);
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    amt_d   = amt_q;
    stage_d = stage_q;
    odata_d = odata_q;
    ozero_d = ozero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = mode_t'(in_mode);
          data_d  = ld_data;
          amt_d   = ld_amt;
          stage_d = SHW'(1);
          state_d = SHIFT;
`ifdef SEQ_BARREL_SHIFTER_FAST_PATH_EN
          if (ld_amt == '0) begin
            state_d = DONE;
            odata_d = ld_data;
            ozero_d = (ld_data == '0);
          end
`endif
        end
      end
      SHIFT: begin
        data_d  = shifted;
        stage_d = stage_q << 1;
        if (stage_q[SHW-1]) begin
          state_d = DONE;
          odata_d = shifted;
          ozero_d = (shifted == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= SLL;
      data_q  <= '0;
      amt_q   <= '0;
      stage_q <= '0;
      odata_q <= '0;
      ozero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
      odata_q <= odata_d;
      ozero_q <= ozero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = odata_q;
  assign out_zero  = ozero_q;

endmodule
